// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequencer slice.
// Holds the FSM state encoding and the default Galois feedback polynomial.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // x^4 + x + 1, maximal length (period 15) for a 4-bit register
   localparam logic [3:0] DEFAULT_TAPS = 4'b0010;

endpackage

// File: rtl/lfsr_core.sv
// Galois LFSR datapath: state register with a parallel load and a single-step advance.
// Load has priority over step.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] step_val;

   // The MSB feeds back into bit 0 and into every tapped position
   always_comb begin
      step_val[0] = state_q[WIDTH-1];
      for (int i = 1; i < WIDTH; i++) begin
         step_val[i] = state_q[i-1] ^ (TAPS[i] & state_q[WIDTH-1]);
      end
      state_d = state_q;
      if (load) begin
         state_d = load_val;
      end else if (step) begin
         state_d = step_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer for a Galois LFSR: captures seed/nsteps on start, streams samples over valid/ready.
// Optional zero-seed lockup reporting is enabled by defining LFSR_LOCKUP_DETECT_EN.
module lfsr_seq_ctrl
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
   parameter int               CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] nsteps,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
`ifdef LFSR_LOCKUP_DETECT_EN
   output logic             lockup_err,
`endif
   output logic             done
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [CNT_W-1:0] nsteps_q, nsteps_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef LFSR_LOCKUP_DETECT_EN
   logic             lockup_q, lockup_d;
`endif

   logic             lfsr_load;
   logic             lfsr_step;
   logic [WIDTH-1:0] lfsr_load_val;
   logic [WIDTH-1:0] lfsr_state;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_lfsr_core (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .step     (lfsr_step),
      .state    (lfsr_state)
   );

   always_comb begin
      state_d       = state_q;
      seed_d        = seed_q;
      nsteps_d      = nsteps_q;
      cnt_d         = cnt_q;
      lfsr_load     = 1'b0;
      lfsr_step     = 1'b0;
      lfsr_load_val = seed_q;
`ifdef LFSR_LOCKUP_DETECT_EN
      lockup_d      = 1'b0;
`else
      // An all-zero state would never leave zero, so substitute the smallest live seed
      if (seed_q == '0) begin
         lfsr_load_val = WIDTH'(1);
      end
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               seed_d   = seed;
               nsteps_d = nsteps;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            lfsr_load = 1'b1;
            cnt_d     = nsteps_q;
`ifdef LFSR_LOCKUP_DETECT_EN
            if (seed_q == '0) begin
               state_d  = DONE;
               lockup_d = 1'b1;
            end else
`endif
            if (nsteps_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (out_ready) begin
               lfsr_step = 1'b1;
               cnt_d     = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      out_valid_d = (state_d == RUN);
      busy_d      = (state_d == LOAD) || (state_d == RUN);
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         seed_q      <= '0;
         nsteps_q    <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef LFSR_LOCKUP_DETECT_EN
         lockup_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         nsteps_q    <= nsteps_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef LFSR_LOCKUP_DETECT_EN
         lockup_q    <= lockup_d;
`endif
      end
   end

   assign out_data  = lfsr_state;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef LFSR_LOCKUP_DETECT_EN
   assign lockup_err = lockup_q;
`endif

endmodule
